mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, SRAM address width in bits.
REQ-003 SHALL have parameter RD_LAT, default 0, source read latency in cycles; legal range 0..4.
REQ-004 SHALL have port clock, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, command request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit, synchronous cancel of the active command.
REQ-008 SHALL have port mode, input, 1 bit, 0 = COPY, 1 = FILL.
REQ-009 SHALL have ports src_base and dst_base, input, ADDR_WIDTH each, start addresses.
REQ-010 SHALL have ports src_stride and dst_stride, input, ADDR_WIDTH each, address increment per word.
REQ-011 SHALL have port length, input, ADDR_WIDTH+1, word count.
REQ-012 SHALL have port fill_value, input, DATA_WIDTH, word written in FILL mode.
REQ-013 SHALL have port src_ReadAddress, output, ADDR_WIDTH, source SRAM read address.
REQ-014 SHALL have port src_ReadBus, input, DATA_WIDTH, source SRAM read data.
REQ-015 SHALL have ports dst_WriteAddress (ADDR_WIDTH), dst_WriteBus (DATA_WIDTH), dst_WriteEnable (1), all outputs, destination SRAM write port.
REQ-016 SHALL have port busy, output, 1 bit, high in RUN and DRAIN.
REQ-017 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-018 SHALL have port count, output, ADDR_WIDTH+1, words written in current/last command.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE; every output SHALL be registered.
REQ-020 In IDLE with start=1, SHALL latch all command inputs, clear count, and go to RUN; if length=0, SHALL go to DONE instead.
REQ-021 start SHALL be ignored outside IDLE; command inputs SHALL be ignored except when latched.
REQ-022 In RUN, SHALL issue one word per cycle; word i read address = src_base + i*src_stride, write address = dst_base + i*dst_stride, both modulo 2^ADDR_WIDTH (wrap, no error).
REQ-023 Data for an address driven in cycle k is valid on src_ReadBus in cycle k+RD_LAT; the engine SHALL capture it then and assert dst_WriteEnable in cycle k+RD_LAT+1 with the matching write address.
REQ-024 FILL mode SHALL use identical issue timing, write fill_value, and hold src_ReadAddress at its last value.
REQ-025 After issuing word length-1, SHALL move to DRAIN; leave DRAIN when the last write has been performed.
REQ-026 Timing: start sampled at edge t -> first write cycle t+2+RD_LAT, last write t+1+RD_LAT+length, done high for exactly cycle t+2+RD_LAT+length, then IDLE.
REQ-027 count SHALL increment on every write cycle, saturate at length, and hold after done until next accepted start.
REQ-028 dst_WriteEnable SHALL be 0 in all cycles not carrying a valid word; write bus/address SHALL hold last value when disabled.
REQ-029 abort=1 in RUN or DRAIN SHALL return to IDLE next edge, discard in-flight reads (no further writes), not pulse done, and leave count at writes completed; abort in IDLE/DONE SHALL have no effect.
REQ-030 abort and start together in IDLE: abort SHALL take priority; command not accepted.
REQ-031 length = 2^ADDR_WIDTH SHALL be legal and write every address exactly once when stride = 1.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE and zero every output, counter and pipeline valid bit, regardless of state.
REQ-033 After reset_n rises, the first start SHALL be accepted no earlier than the next rising edge.

Verification
REQ-034 COPY, RD_LAT=0, src_base=0, dst_base=0x100, strides 1, length 4, src words 0xA0..0xA3 -> dst 0x100..0x103 = 0xA0..0xA3, writes in cycles t+2..t+5, done at t+6, count=4.
REQ-035 FILL, dst_base=0xFFFE, dst_stride=1, length 3, fill_value=0x55 -> writes to 0xFFFE, 0xFFFF, 0x0000 all 0x55, done once.
REQ-036 RD_LAT=3, COPY length 2, src_stride=4 -> reads 0x0, 0x4; first write at t+5, done at t+7.
REQ-037 length=0 start -> no write, done at t+1, busy never high, count=0.
REQ-038 abort asserted at third write cycle of length 10 copy -> exactly 2 or 3 writes per REQ-029 (3 if write already registered), no done, next start accepted normally.
REQ-039 reset_n pulsed low mid-RUN -> all outputs 0 immediately, no write after reset release until new start.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Source/destination SRAM port bundle for mem_copy_engine.
//   master : engine side (drives read address and the write port)
//   slave  : memory side (returns read data, consumes writes)
//   src_ReadAddress  - source SRAM read address
//   src_ReadBus      - source SRAM read data
//   dst_WriteAddress - destination SRAM write address
//   dst_WriteBus     - destination SRAM write data
//   dst_WriteEnable  - destination SRAM write strobe
interface mem_copy_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] src_ReadAddress;
  logic [DATA_WIDTH-1:0] src_ReadBus;
  logic [ADDR_WIDTH-1:0] dst_WriteAddress;
  logic [DATA_WIDTH-1:0] dst_WriteBus;
  logic                  dst_WriteEnable;

  modport master (
    output src_ReadAddress,
    input  src_ReadBus,
    output dst_WriteAddress,
    output dst_WriteBus,
    output dst_WriteEnable
  );

  modport slave (
    input  src_ReadAddress,
    output src_ReadBus,
    input  dst_WriteAddress,
    input  dst_WriteBus,
    input  dst_WriteEnable
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Strided SRAM-to-SRAM copy / fill engine, one word per cycle.
//   clock, reset_n        - clock and asynchronous active-low reset
//   start, abort          - command request (IDLE only) and cancel
//   mode                  - 0 = COPY, 1 = FILL
//   src/dst_base, stride  - start address and per-word increment
//   length                - word count (0 .. 2^ADDR_WIDTH)
//   fill_value            - word written in FILL mode
//   mem                   - SRAM read/write ports (master side)
//   busy, done, count     - status: RUN/DRAIN, completion pulse, words written
module mem_copy_engine #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LAT     = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] src_stride,
  input  logic [ADDR_WIDTH-1:0] dst_stride,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  mem_copy_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_WIDTH-1:0] src_stride_q, src_stride_d;
  logic [ADDR_WIDTH-1:0] dst_stride_q, dst_stride_d;
  logic [LW-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [LW-1:0]         issued_q, issued_d;
  logic [RD_LAT:0]       vpipe_q, vpipe_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LW-1:0]         count_q, count_d;

  // Next-state logic: issue side walks the source, vpipe tracks words in flight
  // through the read latency, capture side writes the destination.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    len_d        = len_q;
    fill_d       = fill_q;
    issued_d     = issued_q;
    vpipe_d      = '0;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    we_d         = 1'b0;
    done_d       = 1'b0;
    count_d      = count_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d       = mode;
          src_ptr_d    = src_base;
          dst_ptr_d    = dst_base;
          src_stride_d = src_stride;
          dst_stride_d = dst_stride;
          len_d        = length;
          fill_d       = fill_value;
          issued_d     = '0;
          count_d      = '0;
          state_d      = (length == '0) ? DONE : RUN;
        end
      end
      RUN, DRAIN: begin
        // Abort leaves vpipe/we at their cleared defaults: in-flight reads are dropped.
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (state_q == RUN) begin
            vpipe_d[0] = 1'b1;
            if (!mode_q) begin
              rd_addr_d = src_ptr_q;
            end
            src_ptr_d = src_ptr_q + src_stride_q;
            issued_d  = issued_q + LW'(1);
            if (issued_q + LW'(1) == len_q) begin
              state_d = DRAIN;
            end
          end
          for (int unsigned j = 1; j <= RD_LAT; j++) begin
            vpipe_d[j] = vpipe_q[j-1];
          end
          if (vpipe_q[RD_LAT] && (count_q != len_q)) begin
            we_d      = 1'b1;
            wr_addr_d = dst_ptr_q;
            wr_data_d = mode_q ? fill_q : mem.src_ReadBus;
            dst_ptr_d = dst_ptr_q + dst_stride_q;
            count_d   = count_q + LW'(1);
            if (count_q + LW'(1) == len_q) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      issued_q     <= '0;
      vpipe_q      <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      issued_q     <= issued_d;
      vpipe_q      <= vpipe_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign mem.src_ReadAddress  = rd_addr_q;
  assign mem.dst_WriteAddress = wr_addr_q;
  assign mem.dst_WriteBus     = wr_data_q;
  assign mem.dst_WriteEnable  = we_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign count                = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a vector table of whole commands on a
// RD_LAT=0 and a RD_LAT=3 instance, plus hand-written abort, reset and
// full-address-space sequences (the last on a 4-bit-address instance).
module tb_mem_copy_engine;
  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 16;
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned SDW = 8;
  localparam int unsigned SAW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          reset_n;
  logic          start0, start3, abort, mode;
  logic [AW-1:0] src_base, dst_base, src_stride, dst_stride;
  logic [LW-1:0] length;
  logic [DW-1:0] fill_value;
  logic          busy0, done0, busy3, done3;
  logic [LW-1:0] count0, count3;

  logic           s_start, s_abort, s_mode;
  logic [SAW-1:0] s_src_base, s_dst_base, s_src_stride, s_dst_stride;
  logic [SAW:0]   s_length;
  logic [SDW-1:0] s_fill;
  logic           s_busy, s_done;
  logic [SAW:0]   s_count;

  mem_copy_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW))  m0 ();
  mem_copy_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW))  m3 ();
  mem_copy_if #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) ms ();

  mem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .abort(abort), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .src_stride(src_stride),
    .dst_stride(dst_stride), .length(length), .fill_value(fill_value),
    .mem(m0), .busy(busy0), .done(done0), .count(count0));

  mem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .abort(abort), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .src_stride(src_stride),
    .dst_stride(dst_stride), .length(length), .fill_value(fill_value),
    .mem(m3), .busy(busy3), .done(done3), .count(count3));

  mem_copy_engine #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .RD_LAT(1)) u_duts (
    .clock(clock), .reset_n(reset_n), .start(s_start), .abort(s_abort), .mode(s_mode),
    .src_base(s_src_base), .dst_base(s_dst_base), .src_stride(s_src_stride),
    .dst_stride(s_dst_stride), .length(s_length), .fill_value(s_fill),
    .mem(ms), .busy(s_busy), .done(s_done), .count(s_count));

  // Source memories: word at address a holds 0xA0 + a (small one: a ^ 0x3C).
  logic [AW-1:0]  rd3_q [3];
  logic [SAW-1:0] rds_q;
  always @(posedge clock) begin
    rd3_q[0] <= m3.src_ReadAddress;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
    rds_q    <= ms.src_ReadAddress;
  end
  assign m0.src_ReadBus = DW'(m0.src_ReadAddress) + DW'(8'hA0);
  assign m3.src_ReadBus = DW'(rd3_q[2]) + DW'(8'hA0);
  assign ms.src_ReadBus = SDW'(rds_q) ^ SDW'(8'h3C);

  // Probe of whichever wide instance the current vector targets.
  int            sel = 0;
  logic          p_we, p_busy, p_done;
  logic [AW-1:0] p_wa, p_ra;
  logic [DW-1:0] p_wd;
  logic [LW-1:0] p_cnt;
  always_comb begin
    if (sel == 1) begin
      p_we = m3.dst_WriteEnable; p_wa = m3.dst_WriteAddress; p_wd = m3.dst_WriteBus;
      p_ra = m3.src_ReadAddress; p_busy = busy3; p_done = done3; p_cnt = count3;
    end else begin
      p_we = m0.dst_WriteEnable; p_wa = m0.dst_WriteAddress; p_wd = m0.dst_WriteBus;
      p_ra = m0.src_ReadAddress; p_busy = busy0; p_done = done0; p_cnt = count0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            sel;
    logic          mode;
    logic [AW-1:0] sb, db, ss, ds;
    logic [LW-1:0] len;
    logic [DW-1:0] fill;
    int            e_nwr, e_first, e_done, e_busy;
    logic [AW-1:0] e_fwa, e_lwa, e_ra;
    logic [DW-1:0] e_fwd, e_lwd;
  } vec_t;

  // Launch a command; returns at the negedge of the cycle after the start edge.
  task automatic drive(input vec_t v);
    @(negedge clock);
    sel = v.sel; mode = v.mode; src_base = v.sb; dst_base = v.db;
    src_stride = v.ss; dst_stride = v.ds; length = v.len; fill_value = v.fill;
    if (v.sel == 1) start3 = 1'b1; else start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0; start3 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nwr = 0, ndone = 0, done_at = -1, first = -1, nbusy = 0;
    logic [AW-1:0] fwa = '0, lwa = '0;
    logic [DW-1:0] fwd = '0, lwd = '0;
    drive(v);
    for (int c = 0; c < 40; c++) begin
      if (p_we) begin
        if (nwr == 0) begin first = c; fwa = p_wa; fwd = p_wd; end
        lwa = p_wa; lwd = p_wd; nwr++;
      end
      if (p_done) begin ndone++; if (done_at < 0) done_at = c; end
      if (p_busy) nbusy++;
      if (done_at >= 0 && c >= done_at + 2) break;
      @(negedge clock);
    end
    chk({tag, "_nwr"},   DW'(nwr),     DW'(v.e_nwr));
    chk({tag, "_ndone"}, DW'(ndone),   DW'(1));
    chk({tag, "_doneat"},DW'(done_at), DW'(v.e_done));
    chk({tag, "_busy"},  DW'(nbusy),   DW'(v.e_busy));
    chk({tag, "_count"}, DW'(p_cnt),   DW'(v.e_nwr));
    chk({tag, "_ra"},    DW'(p_ra),    DW'(v.e_ra));
    if (v.e_nwr > 0) begin
      chk({tag, "_first"}, DW'(first), DW'(v.e_first));
      chk({tag, "_fwa"},   DW'(fwa),   DW'(v.e_fwa));
      chk({tag, "_fwd"},   fwd,        v.e_fwd);
      chk({tag, "_lwa"},   DW'(lwa),   DW'(v.e_lwa));
      chk({tag, "_lwd"},   lwd,        v.e_lwd);
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  int   nwr, ndone, nbusy, dup, derr;
  logic [15:0]    seen;
  logic [SAW-1:0] sa;

  initial begin
    // sel mode sb db ss ds len fill | nwr first done busy fwa lwa ra fwd lwd
    vecs[0] = '{0, 1'b0, 16'h0000, 16'h0100, 16'h1, 16'h1, 17'd4, 128'h0,
                4, 2, 6, 5, 16'h0100, 16'h0103, 16'h0003, 128'hA0, 128'hA3};
    vecs[1] = '{0, 1'b1, 16'h0777, 16'hFFFE, 16'h1, 16'h1, 17'd3, 128'h55,
                3, 2, 5, 4, 16'hFFFE, 16'h0000, 16'h0003, 128'h55, 128'h55};
    vecs[2] = '{1, 1'b0, 16'h0000, 16'h0020, 16'h4, 16'h1, 17'd2, 128'h0,
                2, 5, 7, 6, 16'h0020, 16'h0021, 16'h0004, 128'hA0, 128'hA4};
    vecs[3] = '{0, 1'b0, 16'h0040, 16'h0050, 16'h1, 16'h1, 17'd0, 128'h0,
                0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0003, 128'h0, 128'h0};
    vecs[4] = '{1, 1'b1, 16'h0900, 16'h0040, 16'h1, 16'h1, 17'd1, 128'h77,
                1, 5, 6, 5, 16'h0040, 16'h0040, 16'h0004, 128'h77, 128'h77};
    vecs[5] = '{0, 1'b0, 16'hFFFF, 16'h0010, 16'h2, 16'h3, 17'd3, 128'h0,
                3, 2, 5, 4, 16'h0010, 16'h0016, 16'h0003, 128'h1009F, 128'hA3};

    reset_n = 1'b0; start0 = 1'b0; start3 = 1'b0; abort = 1'b0; mode = 1'b0;
    src_base = '0; dst_base = '0; src_stride = '0; dst_stride = '0;
    length = '0; fill_value = '0;
    s_start = 1'b0; s_abort = 1'b0; s_mode = 1'b0; s_src_base = '0;
    s_dst_base = '0; s_src_stride = '0; s_dst_stride = '0; s_length = '0; s_fill = '0;

    repeat (3) @(negedge clock);
    chk("rst_we0",   DW'(m0.dst_WriteEnable), DW'(0));
    chk("rst_busy0", DW'(busy0),  DW'(0));
    chk("rst_done3", DW'(done3),  DW'(0));
    chk("rst_cnt3",  DW'(count3), DW'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy3", DW'(busy3), DW'(0));
    chk("idle_ra0",   DW'(m0.src_ReadAddress), DW'(0));

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort during the third write cycle of a 10-word copy.
    v = vecs[0]; v.db = 16'h0200; v.len = 17'd10;
    drive(v);
    nwr = 0; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (p_we) nwr++;
      if (p_done) ndone++;
      if (c == 4) begin
        chk("abort_at_we", DW'(p_we), DW'(1));
        abort = 1'b1;
      end
      if (c == 5) abort = 1'b0;
      @(negedge clock);
    end
    chk("abort_nwr",   DW'(nwr),   DW'(3));
    chk("abort_ndone", DW'(ndone), DW'(0));
    chk("abort_cnt",   DW'(count0), DW'(3));
    chk("abort_busy",  DW'(busy0), DW'(0));
    run_vec(vecs[0], "after_abort");

    // start together with abort in IDLE: command must not be accepted.
    @(negedge clock);
    sel = 0; mode = 1'b0; length = 17'd4; start0 = 1'b1; abort = 1'b1;
    @(negedge clock);
    start0 = 1'b0; abort = 1'b0;
    nbusy = 0; nwr = 0; ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy0) nbusy++;
      if (m0.dst_WriteEnable) nwr++;
      if (done0) ndone++;
      @(negedge clock);
    end
    chk("absrt_busy", DW'(nbusy), DW'(0));
    chk("absrt_nwr",  DW'(nwr),   DW'(0));
    chk("absrt_done", DW'(ndone), DW'(0));
    chk("absrt_cnt",  DW'(count0), DW'(4));

    // Reset pulse in the middle of a copy.
    v = vecs[0]; v.db = 16'h0300; v.len = 17'd10;
    drive(v);
    repeat (3) @(negedge clock);
    chk("rstrun_pre_we", DW'(m0.dst_WriteEnable), DW'(1));
    reset_n = 1'b0;
    #1;
    chk("rstrun_we",   DW'(m0.dst_WriteEnable),  DW'(0));
    chk("rstrun_wa",   DW'(m0.dst_WriteAddress), DW'(0));
    chk("rstrun_wd",   m0.dst_WriteBus,          DW'(0));
    chk("rstrun_ra",   DW'(m0.src_ReadAddress),  DW'(0));
    chk("rstrun_busy", DW'(busy0),  DW'(0));
    chk("rstrun_cnt",  DW'(count0), DW'(0));
    @(negedge clock);
    reset_n = 1'b1;
    nwr = 0; ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (m0.dst_WriteEnable) nwr++;
      if (done0) ndone++;
    end
    chk("rstrun_post_nwr",  DW'(nwr),   DW'(0));
    chk("rstrun_post_done", DW'(ndone), DW'(0));
    run_vec(vecs[0], "after_rst");

    // Full 4-bit address space, stride 1, RD_LAT=1: each address written once.
    @(negedge clock);
    s_mode = 1'b0; s_src_base = 4'h0; s_dst_base = 4'h5; s_src_stride = 4'h1;
    s_dst_stride = 4'h1; s_length = 5'd16; s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    nwr = 0; ndone = 0; dup = 0; derr = 0; seen = '0;
    for (int c = 0; c < 30; c++) begin
      if (ms.dst_WriteEnable) begin
        nwr++;
        if (seen[ms.dst_WriteAddress]) dup++;
        seen[ms.dst_WriteAddress] = 1'b1;
        sa = ms.dst_WriteAddress - 4'h5;
        if (ms.dst_WriteBus !== (SDW'(sa) ^ SDW'(8'h3C))) derr++;
      end
      if (s_done) ndone++;
      @(negedge clock);
    end
    chk("full_nwr",  DW'(nwr),     DW'(16));
    chk("full_dup",  DW'(dup),     DW'(0));
    chk("full_seen", DW'(seen),    DW'(16'hFFFF));
    chk("full_data", DW'(derr),    DW'(0));
    chk("full_done", DW'(ndone),   DW'(1));
    chk("full_cnt",  DW'(s_count), DW'(16));
    chk("full_busy", DW'(s_busy),  DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
